// File: rtl/pkt_filter_pkg.sv
// Shared types and defaults for the packet filter stage.
package pkt_filter_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } filt_state_e;

  typedef struct packed {
    logic                  val;
    logic                  sop;
    logic                  eop;
    logic [DEF_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/pkt_filter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pkt_filter.sv
// Forwards whole packets when enabled, drops disabled/malformed ones and
// truncates a packet cut short by a protocol error; counts passes and drops.
module pkt_filter
  import pkt_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              val,
  input  logic              sop,
  input  logic              eop,
  input  logic [DATA_W-1:0] data,
  input  logic              port_enable,
  input  logic              fsm_error,
  input  logic              cnt_clr,
  output logic              out_val,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              s1_val, s1_sop, s1_eop;
  logic [DATA_W-1:0] s1_data;

  filt_state_e state, state_nxt;

  logic fwd, fwd_sop, fwd_eop, fwd_err;
  logic pass_inc, drop_inc;

  // S1 holds the beat that fsm_error refers to this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_val  <= 1'b0;
      s1_sop  <= 1'b0;
      s1_eop  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_val  <= val;
      s1_sop  <= sop;
      s1_eop  <= eop;
      s1_data <= data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    fwd_sop   = 1'b0;
    fwd_eop   = 1'b0;
    fwd_err   = 1'b0;
    pass_inc  = 1'b0;
    drop_inc  = 1'b0;
    if (s1_val) begin
      case (state)
        ST_IDLE: begin
          if (s1_sop && !fsm_error) begin
            if (port_enable) begin
              fwd       = 1'b1;
              fwd_sop   = 1'b1;
              fwd_eop   = s1_eop;
              pass_inc  = 1'b1;
              state_nxt = s1_eop ? ST_IDLE : ST_PASS;
            end else begin
              drop_inc  = 1'b1;
              state_nxt = s1_eop ? ST_IDLE : ST_DROP;
            end
          end
        end
        ST_PASS: begin
          // An intruding sop closes the current packet with an error flag.
          if (fsm_error || (s1_sop && s1_eop)) begin
            fwd       = 1'b1;
            fwd_eop   = 1'b1;
            fwd_err   = 1'b1;
            drop_inc  = 1'b1;
            state_nxt = ST_DROP;
          end else begin
            fwd     = 1'b1;
            fwd_eop = s1_eop;
            if (s1_eop)
              state_nxt = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (s1_eop)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      out_val  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_err  <= 1'b0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      out_val  <= fwd;
      out_sop  <= fwd_sop;
      out_eop  <= fwd_eop;
      out_err  <= fwd_err;
      out_data <= fwd ? s1_data : '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pass_inc),
    .clr   (cnt_clr),
    .cnt   (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .clr   (cnt_clr),
    .cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_pkt_filter.sv
// Self-checking bench for pkt_filter: directed scenarios plus random traffic
// compared cycle by cycle against a packet-level reference model.
module tb_pkt_filter;
  import pkt_filter_pkg::*;

  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          val = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [DW-1:0] data = '0;
  logic          port_enable = 1'b0, fsm_error = 1'b0, cnt_clr = 1'b0;
  logic          out_val, out_sop, out_eop, out_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] pass_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  pkt_filter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .val         (val),
    .sop         (sop),
    .eop         (eop),
    .data        (data),
    .port_enable (port_enable),
    .fsm_error   (fsm_error),
    .cnt_clr     (cnt_clr),
    .out_val     (out_val),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_err     (out_err),
    .out_data    (out_data),
    .pass_cnt    (pass_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what happens to the rest of the current packet.
  localparam int M_NONE = 0, M_KEEP = 1, M_DISCARD = 2;
  beat_t       m_s1 = '0;
  int          m_mode = M_NONE;
  logic [11:0] exp_out = '0;
  int          exp_pass = 0, exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic v, input logic s, input logic e, input logic [7:0] d);
    return beat_t'({v, s, e, d});
  endfunction

  function automatic int bump(input int c, input logic inc, input logic clr);
    if (clr) return 0;
    if (inc && c < CMAX) return c + 1;
    return c;
  endfunction

  task automatic model_step(input logic err, input logic en, input logic clr);
    beat_t b;
    logic  ip, id;
    b = m_s1;
    ip = 1'b0;
    id = 1'b0;
    exp_out = '0;
    if (b.val) begin
      if (m_mode == M_NONE) begin
        if (b.sop && !err) begin
          if (en) begin
            exp_out = {1'b1, 1'b1, b.eop, 1'b0, b.data};
            ip = 1'b1;
            m_mode = b.eop ? M_NONE : M_KEEP;
          end else begin
            id = 1'b1;
            m_mode = b.eop ? M_NONE : M_DISCARD;
          end
        end
      end else if (m_mode == M_KEEP) begin
        if (err || (b.sop && b.eop)) begin
          exp_out = {1'b1, 1'b0, 1'b1, 1'b1, b.data};
          id = 1'b1;
          m_mode = M_DISCARD;
        end else begin
          exp_out = {1'b1, 1'b0, b.eop, 1'b0, b.data};
          if (b.eop) m_mode = M_NONE;
        end
      end else if (b.eop) begin
        m_mode = M_NONE;
      end
    end
    exp_pass = bump(exp_pass, ip, clr);
    exp_drop = bump(exp_drop, id, clr);
  endtask

  // err/en refer to the beat presented on the previous step (now in S1).
  task automatic step(input beat_t b, input logic err, input logic en, input logic clr);
    @(negedge clk);
    {val, sop, eop, data} = b;
    fsm_error   = err;
    port_enable = en;
    cnt_clr     = clr;
    model_step(err, en, clr);
    m_s1 = b;
    @(posedge clk);
    #1;
    check("out_beat", {20'b0, out_val, out_sop, out_eop, out_err, out_data}, {20'b0, exp_out});
    check("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(mk(0, 0, 0, 8'h00), 1'b0, en, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {val, sop, eop, data} = '0;
    fsm_error = 1'b0;
    cnt_clr   = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_out", {20'b0, out_val, out_sop, out_eop, out_err, out_data}, 32'h0);
    check("rst_pass", 32'(pass_cnt), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    m_s1 = '0; m_mode = M_NONE; exp_out = '0; exp_pass = 0; exp_drop = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int    rem;
    beat_t b;
    logic  err, en, clr, intr, prev_intr;

    // Reset in the middle of an enabled packet, then a stray non-sop beat.
    step(mk(1, 1, 0, 8'h5A), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 0, 8'h5B), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 0, 8'h5C), 1'b0, 1'b1, 1'b0);
    do_reset();
    step(mk(1, 0, 1, 8'h77), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("stray_not_fwd", 32'(pass_cnt), 32'h0);

    // Enabled 3-beat packet.
    step(mk(1, 1, 0, 8'h11), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 0, 8'h22), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 1, 8'h33), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("en3_pass", 32'(pass_cnt), 32'd1);
    check("en3_drop", 32'(drop_cnt), 32'd0);

    // Disabled 4-beat packet then a single-beat packet.
    do_reset();
    for (int i = 0; i < 4; i++) step(mk(1, i == 0, i == 3, 8'(8'h40 + i)), 1'b0, 1'b0, 1'b0);
    step(mk(1, 1, 1, 8'hAA), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("dis_drop", 32'(drop_cnt), 32'd2);
    check("dis_pass", 32'(pass_cnt), 32'd0);

    // Truncation by an intruding sop flagged one cycle later.
    do_reset();
    step(mk(1, 1, 0, 8'h01), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 0, 8'h02), 1'b0, 1'b1, 1'b0);
    step(mk(1, 1, 0, 8'h03), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 0, 8'h04), 1'b1, 1'b1, 1'b0);
    step(mk(1, 0, 1, 8'h05), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("trunc_pass", 32'(pass_cnt), 32'd1);
    check("trunc_drop", 32'(drop_cnt), 32'd1);

    // sop+eop inside a packet without fsm_error is also a violation.
    do_reset();
    step(mk(1, 1, 0, 8'hC1), 1'b0, 1'b1, 1'b0);
    step(mk(1, 1, 1, 8'hC2), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 1, 8'hC3), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("sopeop_drop", 32'(drop_cnt), 32'd1);

    // Saturation then clear colliding with an increment.
    do_reset();
    for (int i = 0; i < 5; i++) step(mk(1, 1, 1, 8'(8'h90 + i)), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("sat_pass", 32'(pass_cnt), 32'd3);
    step(mk(1, 1, 1, 8'h96), 1'b0, 1'b1, 1'b0);
    step(mk(0, 0, 0, 8'h00), 1'b0, 1'b1, 1'b1);
    check("clr_wins", 32'(pass_cnt), 32'd0);

    // port_enable dropping mid-packet does not truncate; next packet dropped.
    do_reset();
    step(mk(1, 1, 0, 8'hE1), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 0, 8'hE2), 1'b0, 1'b1, 1'b0);
    step(mk(1, 0, 1, 8'hE3), 1'b0, 1'b0, 1'b0);
    step(mk(1, 1, 0, 8'hF1), 1'b0, 1'b0, 1'b0);
    step(mk(1, 0, 1, 8'hF2), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("en_mid_pass", 32'(pass_cnt), 32'd1);
    check("en_mid_drop", 32'(drop_cnt), 32'd1);

    // Random traffic with gaps, junk beats, intruders, errors and clears.
    rem = 0;
    prev_intr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      b = '0;
      intr = 1'b0;
      b.val = ($urandom_range(0, 3) != 0);
      if (b.val) begin
        b.data = 8'($urandom);
        if (rem == 0 && $urandom_range(0, 15) == 0) begin
          b.eop = 1'($urandom_range(0, 1));
        end else begin
          if (rem == 0) begin
            b.sop = 1'b1;
            rem = $urandom_range(1, 5);
          end else if ($urandom_range(0, 11) == 0) begin
            b.sop = 1'b1;
            intr = 1'b1;
            rem = $urandom_range(1, 5);
          end
          b.eop = (rem == 1);
          rem--;
        end
      end
      err = m_s1.val && m_s1.sop &&
            ((prev_intr && $urandom_range(0, 3) != 0) || $urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      step(b, err, en, clr);
      prev_intr = intr;
    end
    idle(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_filter.md
# pkt_filter

Packet filter stage directly downstream of `control_fsm`. It receives the same `val`/`sop`/`eop` beat stream with payload, plus the `enable` and `error` outputs that `control_fsm` produces from that stream. It forwards whole packets only when the port is enabled, drops disabled or malformed packets, and truncates a packet cut short by a protocol error. It also keeps saturating pass/drop counters for the status block.

## Interface
- `DATA_W`, 8, payload width in bits
- `CNT_W`, 16, width of each packet counter
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  asynchronous, active-high reset
- `val`  in  1  input beat valid
- `sop`  in  1  start of packet, qualified by `val`
- `eop`  in  1  end of packet, qualified by `val`
- `data`  in  DATA_W  input payload
- `port_enable`  in  1  `enable` output of `control_fsm`
- `fsm_error`  in  1  `error` output of `control_fsm`
- `cnt_clr`  in  1  synchronous clear of both counters
- `out_val`  out  1  output beat valid
- `out_sop`  out  1  output start of packet
- `out_eop`  out  1  output end of packet
- `out_err`  out  1  output packet terminated by error (valid with `out_eop`)
- `out_data`  out  DATA_W  output payload
- `pass_cnt`  out  CNT_W  packets forwarded (complete or truncated)
- `drop_cnt`  out  CNT_W  packets dropped

## Operation
- **Stage 1 (S1) register:** captures `{val, sop, eop, data}` every cycle. `control_fsm` flags a violating beat one cycle later, so `fsm_error` is aligned with the beat held in S1. All decisions act on the S1 beat together with the current `fsm_error` and `port_enable`.
- **FSM states:** IDLE, PASS, DROP. Reset state is IDLE.
- **IDLE, S1 sop beat, `fsm_error`=0:**
  - `port_enable`=1: forward the beat and increment `pass_cnt`. Next state is PASS, or stays IDLE if `eop` is set on the same beat.
  - `port_enable`=0: discard the beat and increment `drop_cnt`. Next state is DROP, or stays IDLE on a single-beat packet.
- **IDLE, S1 beat with no sop, or any beat with `fsm_error`=1:** discard; no count change; stay IDLE.
- **PASS, S1 beat, `fsm_error`=0:** forward. On `eop`, go to IDLE.
- **PASS, S1 beat, `fsm_error`=1 (sop inside a packet):**
  - Emit this beat with `out_eop`=1, `out_err`=1, `out_sop`=0, data passed through.
  - Go to DROP to discard the intruding packet's tail.
  - Increment `drop_cnt` for the intruding packet.
- **PASS, S1 beat with sop and eop together and no error:** treated as a violation; handled exactly as the `fsm_error`=1 case above.
- **DROP:** discard all beats. An S1 beat with `eop` returns the FSM to IDLE. Once in DROP, `fsm_error` has no further effect.
- **`port_enable` scope:** sampled only at sop in IDLE. Deasserting it mid-packet never truncates a packet.
- **Counters:** saturate at 2^CNT_W−1. If `cnt_clr` and an increment occur in the same cycle, `cnt_clr` wins and the counter becomes 0.
- **Reset values (asynchronous):** all outputs 0, both counters 0, S1 cleared, state IDLE.
- **Reset mid-packet:** the packet in flight is lost without being counted. Beats arriving after reset without a sop are discarded in IDLE.

## Timing
- **Latency:** an input beat at cycle t appears on `out_*` at t+2 (S1 register plus output register). All outputs are registered.
- **Counter update:** at t+2, in the same cycle as the corresponding output beat.
- **Throughput:** one beat per cycle, no backpressure. `out_val` is never asserted on consecutive beats belonging to different packets without an eop between them.
- **`out_sop`/`out_eop`/`out_err`:** asserted only together with `out_val`=1.

## Structure
- **`pkt_filter_pkg`:**
  - `filt_state_e` enum (IDLE, PASS, DROP)
  - default `DATA_W` / `CNT_W` localparams
  - a `beat_t` struct `{val, sop, eop, data}`
- **`sat_counter`:** one natural sub-module (width-parameterised, with inc, clr, and the clear-wins rule), instantiated twice for `pass_cnt` and `drop_cnt`.

## Test plan
- **Reset values:** reset asserted mid-cycle, asynchronously → all outputs 0 immediately; counters 0; a following beat with no sop is not forwarded.
- **Enabled 3-beat packet:** `port_enable`=1, data 0x11, 0x22, 0x33 with sop on beat 0 and eop on beat 2 → identical beats out 2 cycles later; `pass_cnt`=1, `drop_cnt`=0.
- **Disabled packets:** `port_enable`=0, 4-beat packet, then a 1-beat packet (sop+eop, 0xAA) → nothing output; `drop_cnt`=2.
- **Truncation:** sop 0x01, beat 0x02, sop 0x03 (`fsm_error`=1 aligned with S1), 0x04, eop 0x05 → output 0x01 sop, 0x02, 0x03 with eop+err; 0x04 and 0x05 dropped; `pass_cnt`=1, `drop_cnt`=1.
- **Saturation and clear:** CNT_W=2, five enabled single-beat packets → `pass_cnt`=3. Then `cnt_clr` in the same cycle as a sixth packet's increment → `pass_cnt`=0.
- **`port_enable` timing:** `port_enable` drops after sop of a 3-beat packet → all 3 beats forwarded. The next packet is dropped.
